// File: rtl/mem_bus_arbiter_if.sv
// Bundle of the CPU/monitor request channels and the shared downstream data bus.
// master = requesters and bus slave side, slave = arbiter side.
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              mon_req;
  logic              mon_we;
  logic [ADDR_W-1:0] mon_addr;
  logic [DATA_W-1:0] mon_wdata;
  logic              mon_ack;
  logic [DATA_W-1:0] mon_rdata;
  logic              mon_lock;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_owner;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output mon_req, mon_we, mon_addr, mon_wdata, mon_lock,
    output bus_rdata,
    input  cpu_ack, cpu_rdata, mon_ack, mon_rdata,
    input  bus_we, bus_addr, bus_wdata, bus_owner
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  mon_req, mon_we, mon_addr, mon_wdata, mon_lock,
    input  bus_rdata,
    output cpu_ack, cpu_rdata, mon_ack, mon_rdata,
    output bus_we, bus_addr, bus_wdata, bus_owner
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing the data bus between CPU and debug monitor.
// IDLE grants, ACCESS drives the command, RESP acks and returns read data.
module mem_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  mem_bus_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] cpu_hold_q, cpu_hold_d;
  logic [DATA_W-1:0] mon_hold_q, mon_hold_d;

  logic cpu_elig, mon_elig, grant_mon;
  logic resp, rd_resp;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cpu_hold_d = cpu_hold_q;
    mon_hold_d = mon_hold_q;

    cpu_elig  = bus.cpu_req & ~bus.mon_lock;
    mon_elig  = bus.mon_req;
    // On a tie the monitor wins only if the CPU owned the previous transaction.
    grant_mon = mon_elig & (~cpu_elig | ~last_q);

    unique case (state_q)
      IDLE: begin
        if (cpu_elig | mon_elig) begin
          state_d = ACCESS;
          owner_d = grant_mon;
          last_d  = grant_mon;
          we_d    = grant_mon ? bus.mon_we    : bus.cpu_we;
          addr_d  = grant_mon ? bus.mon_addr  : bus.cpu_addr;
          wdata_d = grant_mon ? bus.mon_wdata : bus.cpu_wdata;
        end
      end
      ACCESS: state_d = RESP;
      RESP: begin
        state_d = IDLE;
        if (!we_q) begin
          if (owner_q) mon_hold_d = bus.bus_rdata;
          else         cpu_hold_d = bus.bus_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cpu_hold_q <= '0;
      mon_hold_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cpu_hold_q <= cpu_hold_d;
      mon_hold_q <= mon_hold_d;
    end
  end

  // Read data bypasses the hold register during RESP since bus_rdata is only valid then.
  always_comb begin
    resp    = (state_q == RESP);
    rd_resp = resp & ~we_q;
  end

  assign bus.bus_we    = (state_q == ACCESS) & we_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_wdata = wdata_q;
  assign bus.bus_owner = owner_q;
  assign bus.cpu_ack   = resp & ~owner_q;
  assign bus.mon_ack   = resp & owner_q;
  assign bus.cpu_rdata = (rd_resp & ~owner_q) ? bus.bus_rdata : cpu_hold_q;
  assign bus.mon_rdata = (rd_resp &  owner_q) ? bus.bus_rdata : mon_hold_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench: a transaction-level arbitration/memory model predicts each grant,
// a monitor process pops predictions on every ack and checks bus and read data.
module tb_mem_bus_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Bus slave: synchronous RAM, read data valid the cycle after the address.
  logic [31:0] mem [16];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'hC0DE_0000 + 32'(i);
    end else if (bus.bus_we) begin
      mem[bus.bus_addr[5:2]] <= bus.bus_wdata;
    end
    bus.bus_rdata <= mem[bus.bus_addr[5:2]];
  end

  typedef struct {
    logic        owner;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ack_cyc;
  } exp_t;

  exp_t        q[$];
  bit          mon_en = 1'b0;
  logic [31:0] exp_hold [2];

  // Monitor / checker
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      exp_hold[0] = '0;
      exp_hold[1] = '0;
      q.delete();
    end else if (mon_en) begin
      chk("ack_exclusive", 32'(bus.cpu_ack & bus.mon_ack), 32'd0);
      if (bus.bus_we) begin
        if (q.size() == 0) chk("spurious_bus_we", 32'(q.size()), 32'd1);
        else begin
          chk("we_cycle", 32'(cyc), 32'(q[0].ack_cyc - 1));
          chk("we_flag", 32'(q[0].we), 32'd1);
          chk("we_addr", bus.bus_addr, q[0].addr);
          chk("we_wdata", bus.bus_wdata, q[0].wdata);
        end
      end
      if (bus.cpu_ack || bus.mon_ack) begin
        if (q.size() == 0) chk("spurious_ack", 32'(q.size()), 32'd1);
        else begin
          e = q.pop_front();
          chk("ack_owner", 32'(bus.mon_ack), 32'(e.owner));
          chk("ack_cycle", 32'(cyc), 32'(e.ack_cyc));
          chk("bus_owner", 32'(bus.bus_owner), 32'(e.owner));
          chk("bus_addr", bus.bus_addr, e.addr);
          chk("bus_wdata", bus.bus_wdata, e.wdata);
          if (!e.we) exp_hold[e.owner] = e.rdata;
        end
      end
      chk("cpu_rdata", bus.cpu_rdata, exp_hold[0]);
      chk("mon_rdata", bus.mon_rdata, exp_hold[1]);
      if (q.size() > 0 && cyc > q[0].ack_cyc) begin
        chk("missing_ack", 32'(cyc), 32'(q[0].ack_cyc));
        void'(q.pop_front());
      end
    end
  end

  // Reference model: requester state plus "arbiter free from cycle" bookkeeping.
  logic [31:0] ref_mem [16];
  logic        m_last;
  int          idle_from;
  bit          pend [2];
  bit          svc  [2];
  int          ackc [2];
  logic        c_we [2];
  logic [31:0] c_addr  [2];
  logic [31:0] c_wdata [2];
  bit          lock;

  task automatic model_reset();
    m_last    = 1'b1;
    idle_from = cyc;
    lock      = 1'b0;
    for (int r = 0; r < 2; r++) begin
      pend[r] = 1'b0; svc[r] = 1'b0; ackc[r] = 0;
      c_we[r] = 1'b0; c_addr[r] = '0; c_wdata[r] = '0;
    end
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'hC0DE_0000 + 32'(i);
  endtask

  task automatic drive();
    bus.cpu_req   = pend[0];
    bus.cpu_we    = c_we[0];
    bus.cpu_addr  = c_addr[0];
    bus.cpu_wdata = c_wdata[0];
    bus.mon_req   = pend[1];
    bus.mon_we    = c_we[1];
    bus.mon_addr  = c_addr[1];
    bus.mon_wdata = c_wdata[1];
    bus.mon_lock  = lock;
  endtask

  task automatic new_cmd(input int r);
    logic [3:0] idx;
    idx        = 4'($urandom_range(0, 15));
    pend[r]    = 1'b1;
    c_we[r]    = 1'($urandom_range(0, 1));
    c_addr[r]  = ($urandom_range(0, 1) == 1 ? 32'h0000_2000 : 32'h0000_1000) | {26'd0, idx, 2'b00};
    c_wdata[r] = $urandom;
  endtask

  // Decision taken at the posedge following cycle c.
  task automatic predict(input int c);
    exp_t e;
    bit   ce, me;
    int   w;
    logic [31:0] a;
    if (c >= idle_from) begin
      ce = pend[0] && !lock;
      me = pend[1];
      if (ce || me) begin
        w = (ce && me) ? (m_last ? 0 : 1) : (me ? 1 : 0);
        m_last    = w[0];
        idle_from = c + 3;
        svc[w]    = 1'b1;
        ackc[w]   = c + 2;
        a         = c_addr[w];
        e.owner   = w[0];
        e.we      = c_we[w];
        e.addr    = a;
        e.wdata   = c_wdata[w];
        e.ack_cyc = c + 2;
        if (e.we) begin
          ref_mem[a[5:2]] = e.wdata;
          e.rdata = '0;
        end else begin
          e.rdata = ref_mem[a[5:2]];
        end
        q.push_back(e);
      end
    end
  endtask

  // new_p: chance out of 4 of issuing a new request; abandon/lock_en enable those behaviours.
  task automatic step(input int new_p, input bit abandon, input bit lock_en);
    int c;
    @(negedge clk);
    c = cyc;
    for (int r = 0; r < 2; r++)
      if (svc[r] && ackc[r] == c) begin svc[r] = 1'b0; pend[r] = 1'b0; end
    for (int r = 0; r < 2; r++)
      if (abandon && svc[r] && pend[r] && ackc[r] == c + 1 && $urandom_range(0, 7) == 0)
        pend[r] = 1'b0;
    for (int r = 0; r < 2; r++)
      if (!pend[r] && !svc[r] && int'($urandom_range(0, 3)) < new_p) new_cmd(r);
    if (lock_en && $urandom_range(0, 15) == 0) lock = !lock;
    drive();
    predict(c);
  endtask

  task automatic drain();
    lock = 1'b0;
    for (int i = 0; i < 12; i++) step(0, 0, 0);
  endtask

  initial begin
    bit found;
    model_reset();
    drive();
    @(negedge clk);
    chk("rst_bus_we", 32'(bus.bus_we), 32'd0);
    chk("rst_cpu_ack", 32'(bus.cpu_ack), 32'd0);
    chk("rst_mon_ack", 32'(bus.mon_ack), 32'd0);
    chk("rst_bus_addr", bus.bus_addr, 32'd0);
    chk("rst_bus_wdata", bus.bus_wdata, 32'd0);
    chk("rst_bus_owner", 32'(bus.bus_owner), 32'd0);
    chk("rst_cpu_rdata", bus.cpu_rdata, 32'd0);
    chk("rst_mon_rdata", bus.mon_rdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    mon_en = 1'b1;

    for (int i = 0; i < 2000; i++) step(2, 1, 1);
    drain();

    // Continuous contention: grants must alternate.
    for (int i = 0; i < 15; i++) step(4, 0, 0);
    drain();

    // Lock holds off the CPU indefinitely, release grants two cycles later.
    lock = 1'b1;
    new_cmd(0);
    c_we[0] = 1'b0;
    for (int i = 0; i < 20; i++) step(0, 0, 0);
    lock = 1'b0;
    for (int i = 0; i < 6; i++) step(0, 0, 0);
    drain();

    // Reset during the ACCESS cycle of a CPU write.
    mon_en = 1'b0;
    @(negedge clk);
    pend[0] = 1'b1; c_we[0] = 1'b1; c_addr[0] = 32'h0000_1008; c_wdata[0] = 32'h5A5A_1234;
    drive();
    found = 1'b0;
    for (int i = 0; i < 4 && !found; i++) begin
      @(negedge clk);
      if (bus.bus_we) found = 1'b1;
    end
    chk("midop_we_seen", 32'(found), 32'd1);
    reset = 1'b1;
    #1;
    chk("midop_bus_we", 32'(bus.bus_we), 32'd0);
    chk("midop_cpu_ack", 32'(bus.cpu_ack), 32'd0);
    chk("midop_mon_ack", 32'(bus.mon_ack), 32'd0);
    chk("midop_bus_addr", bus.bus_addr, 32'd0);
    chk("midop_bus_wdata", bus.bus_wdata, 32'd0);
    chk("midop_bus_owner", 32'(bus.bus_owner), 32'd0);
    chk("midop_cpu_rdata", bus.cpu_rdata, 32'd0);
    chk("midop_mon_rdata", bus.mon_rdata, 32'd0);
    pend[0] = 1'b0;
    drive();
    @(negedge clk);
    chk("midop_no_ack", 32'(bus.cpu_ack | bus.mon_ack), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    mon_en = 1'b1;

    // First tie after reset goes to the CPU.
    new_cmd(0);
    new_cmd(1);
    c_we[0] = 1'b0;
    c_we[1] = 1'b0;
    for (int i = 0; i < 8; i++) step(0, 0, 0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares the single data-memory/IO bus between the tinymips CPU data port and the debug monitor. The bus feeds the address decoder, data RAM and IO ports downstream. Each requester gets a req/ack handshake. A three-state FSM serialises accesses with round-robin priority and an optional monitor lock that holds off the CPU. It registers the winner's command and returns read data from the synchronous RAM/IO read path.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.

Ports:
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `cpu_req` in 1: CPU access request; held until `cpu_ack`.
- `cpu_we` in 1: CPU write (1) or read (0).
- `cpu_addr` in ADDR_W: CPU byte address.
- `cpu_wdata` in DATA_W: CPU write data.
- `cpu_ack` out 1: one-cycle completion pulse to the CPU.
- `cpu_rdata` out DATA_W: CPU read data.
- `mon_req` in 1: monitor access request.
- `mon_we` in 1: monitor write (1) or read (0).
- `mon_addr` in ADDR_W: monitor byte address.
- `mon_wdata` in DATA_W: monitor write data.
- `mon_ack` out 1: one-cycle completion pulse to the monitor.
- `mon_rdata` out DATA_W: monitor read data.
- `mon_lock` in 1: while high, the CPU is never granted.
- `bus_we` out 1: write enable to the address decoder.
- `bus_addr` out ADDR_W: shared bus address.
- `bus_wdata` out DATA_W: shared bus write data.
- `bus_rdata` in DATA_W: read data from the decoder mux, valid one cycle after the address.
- `bus_owner` out 1: owner of the current or last transaction; 0 = CPU, 1 = monitor.

## Operation
- **FSM states:** IDLE, ACCESS, RESP. Reset state is IDLE.
- **IDLE:** the arbiter samples the requests.
  - CPU is eligible when `cpu_req & ~mon_lock`; monitor is eligible when `mon_req`.
  - One eligible requester: that requester wins.
  - Both eligible: the requester not equal to `last_owner` wins.
  - No eligible requester: the FSM stays in IDLE.
  - On a win, the winner's we/addr/wdata are latched into the command registers, `bus_owner` and `last_owner` are set to the winner, and the FSM goes to ACCESS.
- **ACCESS:** `bus_addr`/`bus_wdata` drive the latched command. `bus_we` = latched we, for this cycle only. Next state is RESP.
- **RESP:**
  - `bus_rdata` is valid.
  - The owner's ack is high for exactly this cycle.
  - For a read, the owner's rdata output = `bus_rdata` combinationally, and the value is captured into the owner's hold register at the end of the cycle.
  - For a write, the hold register is unchanged.
  - Next state is IDLE.
- **rdata outputs:** outside their RESP cycle, `cpu_rdata`/`mon_rdata` present their hold registers.
- **Command registers:** `bus_addr`/`bus_wdata` hold their latched value in every state. Only the IDLE→ACCESS transition changes them.
- **Requester rules:**
  - A requester keeps req and its command stable until its ack.
  - A requester drops req in the cycle after its ack, unless it is issuing a new request.
  - If req drops before ack, the latched transaction still completes and ack still pulses; the requester ignores it.
- **`mon_lock`** is sampled only in IDLE. Raising it during a CPU transaction does not abort that transaction.
- **Reset**, asserted at any time including mid-transaction:
  - The FSM returns to IDLE immediately.
  - Any in-flight ack is cancelled.
  - `bus_we` = 0.
- **Reset values:**
  - `bus_we`, `cpu_ack`, `mon_ack` = 0.
  - `bus_addr`, `bus_wdata` = 0.
  - Hold registers = 0, so `cpu_rdata` = `mon_rdata` = 0.
  - `bus_owner` = 0.
  - `last_owner` = 1, so the CPU wins the first tie.

## Timing
- **Latency:** req seen in IDLE at cycle N → ACCESS in N+1 → ack in N+2. Fixed 3 cycles.
- **Throughput:** at most one transaction per 3 cycles. The arbiter never grants in RESP.
- **`bus_we`:** at most one high cycle per transaction, only in ACCESS. It is never high in IDLE or RESP.
- **Acks:** `cpu_ack` and `mon_ack` are never high in the same cycle.
- **Continuous contention:** with both requesting continuously, grants strictly alternate, so neither requester waits more than one other transaction.

## Test plan
- **CPU read:** after reset, `cpu_req`=1, `cpu_addr`=0x0000_1004, `bus_rdata`=0xDEAD_BEEF in RESP → `bus_addr`=0x1004 from N+1, `bus_we` stays 0, `cpu_ack` high at N+2 only, `cpu_rdata`=0xDEAD_BEEF thereafter. Monitor outputs unchanged.
- **Monitor write:** `mon_we`=1, addr 0x0000_2000, wdata 0x0000_00A5 → `bus_we` high exactly in cycle N+1 with addr 0x2000 / wdata 0xA5, `mon_ack` at N+2, `mon_rdata` unchanged.
- **Simultaneous requests:** both req held continuously, each re-asserting after ack → grant order CPU, MON, CPU, MON. Acks at cycles N+2, N+5, N+8, N+11.
- **Lock:** `mon_lock`=1 with `cpu_req` held for 20 cycles and no `mon_req` → `cpu_ack` never pulses and the FSM stays in IDLE. Dropping the lock at cycle T → `cpu_ack` at T+2.
- **Reset mid-op:** `reset` pulsed during ACCESS of a write → `bus_we` drops immediately, no ack is issued, all outputs take reset values. The next tie goes to the CPU.
- **Abandoned request:** `cpu_req` dropped during ACCESS → `cpu_ack` still pulses at RESP. The FSM returns to IDLE with no extra grant.
